// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   regval_t       : 32-bit address/data word
//   arb_state_t    : arbiter FSM states
//   TimeoutDefault : default wait budget for a granted transaction
package mem_arbiter_pkg;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StData,
        StDiscard
    } arb_state_t;

    localparam int unsigned TimeoutDefault = 15;

    // Instruction fetches always read the full word.
    localparam logic [3:0] FetchByteEnable = 4'b1111;

endpackage

// File: rtl/mem_arbiter_timeout_counter.sv
// Watchdog for one outstanding memory transaction.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset
//   clear   : restart the count (held while the arbiter is idle)
//   enable  : count this cycle (busy and no memory completion)
//   expired : the current cycle is the last one the transaction may wait
module arb_timeout_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CountWidth = $clog2(TIMEOUT + 1);
    // The count starts at 0 in the first busy cycle, so the TIMEOUT-th
    // waiting cycle sees TIMEOUT-1.
    localparam logic [CountWidth-1:0] Limit = CountWidth'(TIMEOUT - 1);

    logic [CountWidth-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CountWidth'(1);
        end
    end

    assign expired = (count_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and load/store.
// One transaction outstanding at a time; grants are registered so the memory
// strobes appear one cycle after the request is sampled in IDLE.
//   clock, reset                       : clock, synchronous active-high reset
//   fetch_request/address/flush        : fetch-stage request and pipeline flush
//   fetch_data_valid/data/error        : fetch completion pulse, word, timeout
//   data_read/write/address/write_data : memory-stage load/store request
//   data_byte_enable                   : store byte lanes
//   data_done/error/read_data          : load/store completion pulse and result
//   mem_*                              : memory port strobes, address, data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    input  logic        fetch_flush,
    output logic        fetch_data_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_error,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    input  logic [3:0]  data_byte_enable,
    output logic        data_done,
    output logic        data_error,
    output logic [31:0] data_read_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_data_valid,
    input  logic [31:0] mem_read_data
);

    arb_state_t state_q, state_d;
    arb_state_t last_grant_q, last_grant_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    regval_t    addr_q, addr_d;
    regval_t    wdata_q, wdata_d;
    logic [3:0] be_q, be_d;

    logic busy;
    logic expired;
    logic timed_out;
    logic fetch_req_eff;
    logic data_req;

    assign busy          = (state_q != StIdle);
    // A memory completion in the last allowed cycle still wins over timeout.
    assign timed_out     = busy && expired && !mem_data_valid;
    assign fetch_req_eff = fetch_request && !fetch_flush;
    assign data_req      = data_read || data_write;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy && !mem_data_valid),
        .expired (expired)
    );

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        rd_d             = rd_q;
        wr_d             = wr_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        fetch_data_valid = 1'b0;
        fetch_error      = 1'b0;
        data_done        = 1'b0;
        data_error       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Data has priority, but yields to fetch right after a data grant.
                if (data_req && !(last_grant_q == StData && fetch_req_eff)) begin
                    state_d      = StData;
                    last_grant_d = StData;
                    rd_d         = !data_write;
                    wr_d         = data_write;
                    addr_d       = data_address;
                    wdata_d      = data_write_data;
                    be_d         = data_byte_enable;
                end else if (fetch_req_eff) begin
                    state_d      = StFetch;
                    last_grant_d = StFetch;
                    rd_d         = 1'b1;
                    wr_d         = 1'b0;
                    addr_d       = fetch_address;
                    wdata_d      = '0;
                    be_d         = FetchByteEnable;
                end
            end
            StFetch: begin
                if (mem_data_valid || timed_out) begin
                    fetch_data_valid = mem_data_valid && !fetch_flush;
                    fetch_error      = timed_out && !fetch_flush;
                    state_d          = StIdle;
                    rd_d             = 1'b0;
                    wr_d             = 1'b0;
                end else if (fetch_flush) begin
                    // Memory still owes a response; keep strobes up and drop it.
                    state_d = StDiscard;
                end
            end
            StData: begin
                if (mem_data_valid || timed_out) begin
                    data_done  = 1'b1;
                    data_error = timed_out;
                    state_d    = StIdle;
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                end
            end
            StDiscard: begin
                if (mem_data_valid || timed_out) begin
                    state_d = StIdle;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An abandoned transaction must not report anything while in reset.
        if (reset) begin
            fetch_data_valid = 1'b0;
            fetch_error      = 1'b0;
            data_done        = 1'b0;
            data_error       = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= StFetch;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    assign mem_read_enable  = rd_q;
    assign mem_write_enable = wr_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_byte_enable  = be_q;
    assign fetch_data       = mem_read_data;
    assign data_read_data   = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// single transactions checked against a per-transaction timing model.
module tb_mem_arbiter;

    localparam int TO = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_flush;
    logic        fetch_data_valid;
    logic [31:0] fetch_data;
    logic        fetch_error;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [3:0]  data_byte_enable;
    logic        data_done;
    logic        data_error;
    logic [31:0] data_read_data;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_data_valid;
    logic [31:0] mem_read_data;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .TIMEOUT (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_request    (fetch_request),
        .fetch_address    (fetch_address),
        .fetch_flush      (fetch_flush),
        .fetch_data_valid (fetch_data_valid),
        .fetch_data       (fetch_data),
        .fetch_error      (fetch_error),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_address     (data_address),
        .data_write_data  (data_write_data),
        .data_byte_enable (data_byte_enable),
        .data_done        (data_done),
        .data_error       (data_error),
        .data_read_data   (data_read_data),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_byte_enable  (mem_byte_enable),
        .mem_data_valid   (mem_data_valid),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_request    = 1'b0;
        fetch_flush      = 1'b0;
        data_read        = 1'b0;
        data_write       = 1'b0;
        mem_data_valid   = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd_en"}, mem_read_enable, 0);
        chk({tag, "_wr_en"}, mem_write_enable, 0);
        chk({tag, "_fdv"}, fetch_data_valid, 0);
        chk({tag, "_done"}, data_done, 0);
    endtask

    // One isolated transaction. kind: 0 fetch, 1 read, 2 write, 3 read+write.
    // k: strobe cycle (0 = first) in which memory answers; k >= TO never answers.
    // flush_at: strobe cycle in which fetch_flush pulses, or -1.
    // Model: strobes last min(k+1, TO) cycles; the final cycle carries the
    // completion, which is an error exactly when k >= TO; a flushed fetch
    // reports nothing.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdata, input int k,
                           input int flush_at);
        bit is_fetch  = (kind == 0);
        bit is_wr     = (kind >= 2);
        bit timed_out = (k >= TO);
        int last      = timed_out ? TO - 1 : k;
        bit flushed   = 1'b0;
        bit fin;

        tick();
        clear_inputs();
        fetch_request    = is_fetch;
        fetch_address    = addr;
        data_read        = (kind == 1) || (kind == 3);
        data_write       = is_wr;
        data_address     = addr;
        data_write_data  = wdata;
        data_byte_enable = be;
        #2;
        chk_quiet("req_cycle");

        for (int i = 0; i <= last; i++) begin
            tick();
            mem_data_valid = (i == k);
            mem_read_data  = (i == k) ? rdata : $urandom;
            fetch_flush    = (i == flush_at);
            if (i == flush_at) begin
                flushed       = 1'b1;
                fetch_request = 1'b0;
            end
            #2;
            fin = (i == last);
            chk("mem_read_enable", mem_read_enable, !is_wr);
            chk("mem_write_enable", mem_write_enable, is_wr);
            chk("mem_address", mem_address, addr);
            chk("mem_byte_enable", mem_byte_enable, is_fetch ? 4'hF : be);
            if (is_wr) chk("mem_write_data", mem_write_data, wdata);
            chk("fetch_data_valid", fetch_data_valid, is_fetch && fin && !timed_out && !flushed);
            chk("fetch_error", fetch_error, is_fetch && fin && timed_out && !flushed);
            chk("data_done", data_done, !is_fetch && fin);
            chk("data_error", data_error, !is_fetch && fin && timed_out);
            if (is_fetch && fin && !timed_out && !flushed) chk("fetch_data", fetch_data, rdata);
            if (kind == 1 && fin && !timed_out) chk("data_read_data", data_read_data, rdata);
        end

        // Requester drops in the cycle after done; block must be idle again.
        tick();
        clear_inputs();
        #2;
        chk_quiet("after_done");
    endtask

    initial begin
        bit owner_data;
        int kind;
        int k;
        int lim;
        int fl;

        clear_inputs();
        fetch_address    = '0;
        data_address     = '0;
        data_write_data  = '0;
        data_byte_enable = '0;
        mem_read_data    = '0;
        reset            = 1'b1;

        // Reset state
        repeat (2) tick();
        #2;
        chk_quiet("reset");
        chk("reset_addr", mem_address, 0);
        chk("reset_wdata", mem_write_data, 0);
        chk("reset_be", mem_byte_enable, 0);
        chk("reset_ferr", fetch_error, 0);
        chk("reset_derr", data_error, 0);
        tick();
        reset = 1'b0;

        // Fetch only: strobe in cycle 1, word back in cycle 4
        run_txn(0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 3, -1);

        // Contention: last grant was FETCH, so DATA, FETCH, DATA with idle gaps
        tick();
        fetch_request    = 1'b1;
        fetch_address    = 32'h400;
        data_read        = 1'b1;
        data_address     = 32'h500;
        data_byte_enable = 4'h5;
        #2;
        owner_data = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            mem_data_valid = (c % 2 == 1);
            mem_read_data  = 32'hA000_0000 | c;
            #2;
            chk("cont_rd_en", mem_read_enable, c % 2 == 1);
            if (c % 2 == 1) begin
                chk("cont_addr", mem_address, owner_data ? 32'h500 : 32'h400);
                chk("cont_be", mem_byte_enable, owner_data ? 4'h5 : 4'hF);
            end
            chk("cont_data_done", data_done, (c % 2 == 1) && owner_data);
            chk("cont_fetch_valid", fetch_data_valid, (c % 2 == 1) && !owner_data);
            if (c % 2 == 1) owner_data = !owner_data;
        end
        tick();
        clear_inputs();
        #2;
        chk_quiet("cont_end");

        // Store with partial byte enable
        run_txn(2, 32'h2000, 32'h12345678, 4'b0011, 32'h0, 4, -1);

        // Flush mid-fetch, then a normal load
        run_txn(0, 32'h180, 32'h0, 4'h0, 32'hCAFEF00D, 5, 2);
        run_txn(1, 32'h2400, 32'h0, 4'hF, 32'h0BADC0DE, 1, -1);

        // Memory never answers
        run_txn(1, 32'h2800, 32'h0, 4'hF, 32'h0, 1000, -1);

        // Flush in IDLE masks fetch; last grant is DATA so an unmasked fetch would win
        tick();
        fetch_request = 1'b1;
        fetch_flush   = 1'b1;
        fetch_address = 32'h700;
        data_read     = 1'b1;
        data_address  = 32'h600;
        #2;
        tick();
        fetch_request  = 1'b0;
        fetch_flush    = 1'b0;
        mem_data_valid = 1'b1;
        #2;
        chk("mask_addr", mem_address, 32'h600);
        chk("mask_data_done", data_done, 1);
        chk("mask_fetch_valid", fetch_data_valid, 0);
        tick();
        clear_inputs();
        #2;
        chk_quiet("mask_end");

        // Reset while in DATA
        tick();
        data_read    = 1'b1;
        data_address = 32'h3000;
        data_byte_enable = 4'hC;
        #2;
        tick();
        #2;
        chk("rst_pre_rd_en", mem_read_enable, 1);
        tick();
        reset          = 1'b1;
        data_read      = 1'b0;
        mem_data_valid = 1'b1;
        #2;
        chk("rst_cycle_done", data_done, 0);
        chk("rst_cycle_err", data_error, 0);
        tick();
        reset          = 1'b0;
        mem_data_valid = 1'b0;
        #2;
        chk_quiet("rst_after");
        chk("rst_after_addr", mem_address, 0);
        chk("rst_after_be", mem_byte_enable, 0);
        chk("rst_after_wdata", mem_write_data, 0);
        // Stray completion while idle is ignored
        tick();
        mem_data_valid = 1'b1;
        #2;
        chk_quiet("idle_stray");
        tick();
        clear_inputs();

        // Random isolated transactions
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(3, 0);
            k    = $urandom_range(20, 0);
            fl   = -1;
            if (kind == 0 && $urandom_range(2, 0) == 0) begin
                lim = (k < TO) ? k : TO - 1;
                fl  = $urandom_range(lim, 0);
            end
            run_txn(kind, $urandom, $urandom, 4'($urandom), $urandom, k, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
